// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline front end.
//   IF_NOP_INSTR  : instruction word used for IF/ID bubbles
//   IF_RESET_PC   : default fetch address after reset
//   if_state_t    : fetch FSM encoding (FETCH / WAIT / HOLD / DROP)
//   pc_plus4      : 32-bit modulo PC increment
package mips_pkg;

  localparam logic [31:0] IF_NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] IF_RESET_PC  = 32'h0000_3000;

  typedef enum logic [1:0] {
    FETCH = 2'b00,  // request on the bus
    WAIT  = 2'b01,  // granted, awaiting response
    HOLD  = 2'b10,  // response parked in skid buffer while stalled
    DROP  = 2'b11   // outstanding response must be discarded
  } if_state_t;

  // Wraps naturally: 32'hFFFF_FFFC + 4 = 0.
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register.
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   flush_i            force bubble (highest priority), pc4 kept
//   hold_i             keep all fields
//   load_i             capture instr_i / pc4_i as a valid instruction
//   instr_i, pc4_i     incoming instruction and its PC+4
//   instr_o, pc4_o     registered instruction and PC+4
//   valid_o            1 = real instruction, 0 = bubble
// With no control asserted a bubble is loaded (pc4 unchanged).
module if_id_reg
  import mips_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = IF_NOP_INSTR
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        flush_i,
  input  logic        hold_i,
  input  logic        load_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc4_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc4_o,
  output logic        valid_o
);

  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q,   pc4_d;
  logic        valid_q, valid_d;

  // Next-state selection: flush > hold > load > bubble.
  always_comb begin
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    if (flush_i) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else if (hold_i) begin
      instr_d = instr_q;
      valid_d = valid_q;
    end else if (load_i) begin
      instr_d = instr_i;
      pc4_d   = pc4_i;
      valid_d = 1'b1;
    end else begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end
  end

  // Register state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      instr_q <= NOP_INSTR;
      pc4_q   <= 32'h0000_0000;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  assign instr_o = instr_q;
  assign pc4_o   = pc4_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives a single-outstanding
// request/response instruction-memory port and feeds the IF/ID register.
// Ports:
//   clock, reset          clock, asynchronous active-low reset
//   stall                 hold PC and IF/ID
//   redirect, redirect_pc taken branch/jump and its target (bits [1:0] forced 0)
//   imem_req, imem_addr   fetch request and address (= pc_out)
//   imem_gnt              request accepted when imem_req & imem_gnt
//   imem_rvalid, imem_rdata  response
//   IF_ID_im_out, IF_ID_pc4_out, IF_ID_valid  IF/ID register contents
//   pc_out                current fetch PC
//   fetch_cnt             (only with IF_FETCH_CNT_EN) count of valid IF/ID loads
// Optional feature macro: IF_FETCH_CNT_EN.
module if_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = IF_RESET_PC,
  parameter logic [31:0] NOP_INSTR = IF_NOP_INSTR
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IF_ID_im_out,
  output logic [31:0] IF_ID_pc4_out,
  output logic        IF_ID_valid,
  output logic [31:0] pc_out
`ifdef IF_FETCH_CNT_EN
  ,
  output logic [31:0] fetch_cnt
`endif
);

  if_state_t   state_q, state_d;
  logic [31:0] pc_q,    pc_d;
  logic [31:0] skid_q,  skid_d;
  logic        load_s;
  logic [31:0] load_instr_s;
  logic [31:0] target_s;

  assign target_s = redirect_pc & 32'hFFFF_FFFC;

  // Fetch FSM: next state, PC, skid buffer and IF/ID load request.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    skid_d       = skid_q;
    load_s       = 1'b0;
    load_instr_s = imem_rdata;
    case (state_q)
      FETCH: begin
        if (redirect) begin
          pc_d    = target_s;
          // A request granted at the old PC still returns a response.
          state_d = imem_gnt ? DROP : FETCH;
        end else if (imem_gnt) begin
          state_d = WAIT;
        end else begin
          state_d = FETCH;
        end
      end
      WAIT: begin
        if (redirect) begin
          pc_d    = target_s;
          state_d = imem_rvalid ? FETCH : DROP;
        end else if (imem_rvalid && stall) begin
          skid_d  = imem_rdata;
          state_d = HOLD;
        end else if (imem_rvalid) begin
          load_s  = 1'b1;
          pc_d    = pc_plus4(pc_q);
          state_d = FETCH;
        end else begin
          state_d = WAIT;
        end
      end
      HOLD: begin
        if (redirect) begin
          pc_d    = target_s;
          state_d = FETCH;
        end else if (!stall) begin
          load_s       = 1'b1;
          load_instr_s = skid_q;
          pc_d         = pc_plus4(pc_q);
          state_d      = FETCH;
        end else begin
          state_d = HOLD;
        end
      end
      DROP: begin
        if (redirect) begin
          pc_d = target_s;
        end else begin
          pc_d = pc_q;
        end
        state_d = imem_rvalid ? FETCH : DROP;
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  // FSM, PC and skid buffer registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      skid_q  <= NOP_INSTR;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      skid_q  <= skid_d;
    end
  end

  // Gated by the reset pin so no request leaves while reset is held.
  assign imem_req  = reset && (state_q == FETCH);
  assign imem_addr = pc_q;
  assign pc_out    = pc_q;

  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk_i   (clock),
    .rst_ni  (reset),
    .flush_i (redirect),
    .hold_i  (stall),
    .load_i  (load_s),
    .instr_i (load_instr_s),
    .pc4_i   (pc_plus4(pc_q)),
    .instr_o (IF_ID_im_out),
    .pc4_o   (IF_ID_pc4_out),
    .valid_o (IF_ID_valid)
  );

`ifdef IF_FETCH_CNT_EN
  logic [31:0] cnt_q, cnt_d;

  // load_s is only raised without stall or redirect, so it marks real deliveries.
  always_comb begin
    if (load_s) begin
      cnt_d = cnt_q + 32'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Delivered-instruction counter register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= 32'h0000_0000;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign fetch_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;
  logic        clock = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] IF_ID_im_out;
  logic [31:0] IF_ID_pc4_out;
  logic        IF_ID_valid;
  logic [31:0] pc_out;
`ifdef IF_FETCH_CNT_EN
  logic [31:0] fetch_cnt;
`endif

  int checks   = 0;
  int failures = 0;
  int exp_cnt  = 0;

  if_stage dut (
    .clock         (clock),
    .reset         (reset),
    .stall         (stall),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_gnt      (imem_gnt),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .IF_ID_im_out  (IF_ID_im_out),
    .IF_ID_pc4_out (IF_ID_pc4_out),
    .IF_ID_valid   (IF_ID_valid),
    .pc_out        (pc_out)
`ifdef IF_FETCH_CNT_EN
    ,
    .fetch_cnt     (fetch_cnt)
`endif
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req"},   {31'd0, imem_req},    32'd0);
    chk({tag, "_pc"},    pc_out,               32'h0000_3000);
    chk({tag, "_addr"},  imem_addr,            32'h0000_3000);
    chk({tag, "_im"},    IF_ID_im_out,         32'h0000_0000);
    chk({tag, "_pc4"},   IF_ID_pc4_out,        32'h0000_0000);
    chk({tag, "_valid"}, {31'd0, IF_ID_valid}, 32'd0);
  endtask

  // Zero-wait fetch starting in FETCH: grant this cycle, response next.
  task automatic fetch_one(input logic [31:0] instr, input logic [31:0] addr);
    logic [31:0] nxt;
    nxt = addr + 32'd4;
    chk("f_req", {31'd0, imem_req}, 32'd1);
    chk("f_addr", imem_addr, addr);
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    chk("f_wait_req", {31'd0, imem_req}, 32'd0);
    chk("f_wait_valid", {31'd0, IF_ID_valid}, 32'd0);
    imem_rvalid = 1'b1;
    imem_rdata  = instr;
    tick();
    imem_rvalid = 1'b0;
    chk("f_valid", {31'd0, IF_ID_valid}, 32'd1);
    chk("f_im", IF_ID_im_out, instr);
    chk("f_pc4", IF_ID_pc4_out, nxt);
    chk("f_pc", pc_out, nxt);
    exp_cnt++;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'd0;
    #2 reset = 1'b0;
    #2;
    chk_reset_vals("rst");
    tick();
    chk("rst_req_held", {31'd0, imem_req}, 32'd0);
    reset = 1'b1;
    #1;
    chk("rel_req", {31'd0, imem_req}, 32'd1);

    // 1: back-to-back zero-wait fetches
    fetch_one(32'h2408_0001, 32'h0000_3000);
    fetch_one(32'h2409_0002, 32'h0000_3004);
    fetch_one(32'h0109_5020, 32'h0000_3008);

    // 2: response while stalled -> HOLD, release after 3 stall cycles
    stall = 1'b1; imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    chk("s_hold_im0", IF_ID_im_out, 32'h0109_5020);
    imem_rvalid = 1'b1; imem_rdata = 32'hAC0A_0000;
    tick();
    imem_rvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("s_hold_im", IF_ID_im_out, 32'h0109_5020);
      chk("s_hold_valid", {31'd0, IF_ID_valid}, 32'd1);
      chk("s_hold_pc", pc_out, 32'h0000_300C);
      chk("s_hold_req", {31'd0, imem_req}, 32'd0);
      tick();
    end
    chk("s_hold_last_pc4", IF_ID_pc4_out, 32'h0000_300C);
    stall = 1'b0;
    tick();
    chk("s_rel_im", IF_ID_im_out, 32'hAC0A_0000);
    chk("s_rel_pc4", IF_ID_pc4_out, 32'h0000_3010);
    chk("s_rel_valid", {31'd0, IF_ID_valid}, 32'd1);
    chk("s_rel_pc", pc_out, 32'h0000_3010);
    chk("s_rel_req", {31'd0, imem_req}, 32'd1);
    exp_cnt++;

    // 3: redirect while in WAIT -> DROP, next response discarded
    stall = 1'b1; imem_gnt = 1'b1;
    tick();
    stall = 1'b0; imem_gnt = 1'b0;
    redirect = 1'b1; redirect_pc = 32'h0000_3403;
    tick();
    redirect = 1'b0;
    chk("r_pc", pc_out, 32'h0000_3400);
    chk("r_flush_valid", {31'd0, IF_ID_valid}, 32'd0);
    chk("r_flush_im", IF_ID_im_out, 32'h0000_0000);
    chk("r_flush_pc4", IF_ID_pc4_out, 32'h0000_3010);
    chk("r_drop_req", {31'd0, imem_req}, 32'd0);
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_rvalid = 1'b0;
    chk("r_after_valid", {31'd0, IF_ID_valid}, 32'd0);
    fetch_one(32'h8D0B_0004, 32'h0000_3400);

    // 4: redirect + rvalid + stall in the same cycle
    stall = 1'b1; imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    redirect = 1'b1; redirect_pc = 32'h0000_5008; imem_rvalid = 1'b1; imem_rdata = 32'hBAAD_F00D;
    tick();
    redirect = 1'b0; imem_rvalid = 1'b0; stall = 1'b0;
    chk("rs_valid", {31'd0, IF_ID_valid}, 32'd0);
    chk("rs_im", IF_ID_im_out, 32'h0000_0000);
    chk("rs_pc4", IF_ID_pc4_out, 32'h0000_3404);
    chk("rs_pc", pc_out, 32'h0000_5008);
    chk("rs_req", {31'd0, imem_req}, 32'd1);
    chk("rs_addr", imem_addr, 32'h0000_5008);

    // 5: redirect in FETCH without grant, then wrap at top of memory
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE;
    tick();
    redirect = 1'b0;
    chk("w_addr", imem_addr, 32'hFFFF_FFFC);
    fetch_one(32'h1000_FFFF, 32'hFFFF_FFFC);
    chk("w_pc_zero", pc_out, 32'h0000_0000);
`ifdef IF_FETCH_CNT_EN
    chk("cnt_before_rst", fetch_cnt, exp_cnt);
`endif

    // 6: reset asserted mid-WAIT
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    chk("m_wait_req", {31'd0, imem_req}, 32'd0);
    reset = 1'b0;
    #1;
    chk_reset_vals("mrst");
`ifdef IF_FETCH_CNT_EN
    chk("cnt_rst", fetch_cnt, 32'd0);
`endif
    exp_cnt = 0;
    tick();
    reset = 1'b1;
    #1;
    chk("m_rel_req", {31'd0, imem_req}, 32'd1);
    fetch_one(32'h2410_0007, 32'h0000_3000);
`ifdef IF_FETCH_CNT_EN
    chk("cnt_after", fetch_cnt, exp_cnt);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
